// File: rtl/sieve_ram_rd_arbiter.sv
// Read-port arbiter for the sieve bitmap BRAM: picks one requester per cycle (starved, then
// preferred, then round-robin), drives the registered BRAM address and routes read data back by tag.
module sieve_ram_rd_arbiter #(
  parameter int N_REQ    = 2,
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 1,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ-1:0]          prio,
  output logic [N_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]         ram_addr,
  input  logic [DATA_W-1:0]         ram_rd_data,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data
);

  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WCNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_SAT = WCNT_W'(MAX_WAIT);
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(N_REQ - 1);

  logic [N_REQ-1:0]  gnt_reg;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  starved;
  logic [N_REQ-1:0]  preferred;
  logic              win_valid;
  logic [PTR_W-1:0]  win_idx;
  logic [ADDR_W-1:0] ram_addr_reg;
  logic [PTR_W-1:0]  rr_ptr_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic [WCNT_W-1:0] wait_cnt_reg [N_REQ];
  logic [N_REQ-1:0]  tag_reg [RD_LAT];
  logic [ADDR_W-1:0] addr_slot [N_REQ];

  // The requester granted this cycle still shows req high; it is not a new request.
  assign eligible  = req & ~gnt_reg;
  assign preferred = eligible & prio;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign addr_slot[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign starved[gi]   = eligible[gi] && (wait_cnt_reg[gi] == WAIT_SAT);

      always_ff @(posedge clk) begin
        if (rst) begin
          wait_cnt_reg[gi] <= '0;
        end else if (req[gi] && !gnt_reg[gi]) begin
          if (wait_cnt_reg[gi] != WAIT_SAT) begin
            wait_cnt_reg[gi] <= wait_cnt_reg[gi] + 1'b1;
          end
        end else begin
          wait_cnt_reg[gi] <= '0;
        end
      end
    end
  endgenerate

  always_comb begin
    int rr_idx;
    logic [PTR_W-1:0] rr_sel;
    rr_idx    = 0;
    rr_sel    = '0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_valid && starved[i]) begin
        win_valid = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_valid && preferred[i]) begin
        win_valid = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      rr_idx = int'(rr_ptr_reg) + k;
      if (rr_idx >= N_REQ) begin
        rr_idx = rr_idx - N_REQ;
      end
      rr_sel = PTR_W'(rr_idx);
      if (!win_valid && eligible[rr_sel]) begin
        win_valid = 1'b1;
        win_idx   = rr_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_reg      <= '0;
      ram_addr_reg <= '0;
      rr_ptr_reg   <= '0;
    end else begin
      gnt_reg <= '0;
      if (win_valid) begin
        gnt_reg[win_idx] <= 1'b1;
        ram_addr_reg     <= addr_slot[win_idx];
        rr_ptr_reg       <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      end
    end
  end

  // Owner tags ride alongside the BRAM latency so data returns to whoever issued the read.
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_tag
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_reg[gi] <= '0;
        end else if (gi == 0) begin
          tag_reg[gi] <= gnt_reg;
        end else begin
          tag_reg[gi] <= tag_reg[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data_reg <= '0;
    end else if (|tag_reg[RD_LAT-1]) begin
      rsp_data_reg <= ram_rd_data;
    end
  end

  assign gnt       = gnt_reg;
  assign ram_addr  = ram_addr_reg;
  assign rsp_valid = tag_reg[RD_LAT-1];
  assign rsp_data  = (|tag_reg[RD_LAT-1]) ? ram_rd_data : rsp_data_reg;

endmodule

// File: tb/tb_sieve_ram_rd_arbiter.sv
// Bench for sieve_ram_rd_arbiter: BRAM stand-in plus a queue-based reference of grants and
// responses; directed scenarios followed by randomized request traffic.
module tb_sieve_ram_rd_arbiter;
  localparam int N   = 3;
  localparam int AW  = 8;
  localparam int DW  = 4;
  localparam int LAT = 2;
  localparam int MW  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N-1:0]      prio = '0;
  logic [N-1:0]      gnt;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_rd_data;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;

  int total = 0;
  int bad   = 0;

  sieve_ram_rd_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .prio(prio), .gnt(gnt),
    .ram_addr(ram_addr), .ram_rd_data(ram_rd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // BRAM stand-in: fixed contents, data appears LAT cycles after the address.
  logic [DW-1:0] mem [256];
  logic [AW-1:0] apipe [LAT] = '{default: '0};
  always @(posedge clk) begin
    apipe[0] <= ram_addr;
    for (int s = 1; s < LAT; s++) apipe[s] <= apipe[s-1];
  end
  assign ram_rd_data = mem[apipe[LAT-1]];

  // Reference model: arbitration rules in integer form and a queue of due responses.
  typedef struct {int owner; logic [AW-1:0] addr; int due;} rsp_t;
  rsp_t          rspq[$];
  int            cyc = 0;
  int            m_wcnt [N];
  int            m_rr;
  logic [N-1:0]  m_gnt;
  logic [AW-1:0] m_addr;
  logic [N-1:0]  e_rv;
  logic [DW-1:0] e_rd;

  always @(posedge clk) begin
    logic [N-1:0] elig;
    int w;
    cyc++;
    if (rst) begin
      for (int i = 0; i < N; i++) m_wcnt[i] = 0;
      m_gnt = '0; m_rr = 0; m_addr = '0; e_rv = '0; e_rd = '0;
      rspq.delete();
    end else begin
      elig = req & ~m_gnt;
      w = -1;
      for (int i = 0; i < N; i++) if (w < 0 && elig[i] && m_wcnt[i] == MW) w = i;
      for (int i = 0; i < N; i++) if (w < 0 && elig[i] && prio[i]) w = i;
      for (int k = 0; k < N; k++) if (w < 0 && elig[(m_rr + k) % N]) w = (m_rr + k) % N;
      for (int i = 0; i < N; i++)
        m_wcnt[i] = (req[i] && !m_gnt[i]) ? ((m_wcnt[i] < MW) ? m_wcnt[i] + 1 : MW) : 0;
      m_gnt = '0;
      if (w >= 0) begin
        m_gnt[w] = 1'b1;
        m_addr   = req_addr[w*AW +: AW];
        m_rr     = (w + 1) % N;
        rspq.push_back('{w, m_addr, cyc + LAT});
      end
      e_rv = '0;
      if (rspq.size() > 0 && rspq[0].due == cyc) begin
        e_rv[rspq[0].owner] = 1'b1;
        e_rd = mem[rspq[0].addr];
        void'(rspq.pop_front());
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; req = '0; prio = '0;
    repeat (3) @(negedge clk);
    total++; if (gnt !== '0) begin bad++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
    total++; if (ram_addr !== '0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", ram_addr); end
    total++; if (rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=000", rsp_valid); end
    total++; if (rsp_data !== '0) begin bad++; $display("FAIL reset_rsp_data got=%0h exp=0", rsp_data); end
    rst = 1'b0;
    $display("test_reset: gnt=%b ram_addr=%0d rsp_valid=%b", gnt, ram_addr, rsp_valid);
  endtask

  task automatic test_single();
    logic [N-1:0] eg, ev;
    req = 3'b001; req_addr[0 +: AW] = 8'd5;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      eg = (k == 1) ? 3'b001 : 3'b000;
      ev = (k == 3) ? 3'b001 : 3'b000;
      total++; if (gnt !== eg) begin bad++; $display("FAIL single_gnt c%0d got=%b exp=%b", k, gnt, eg); end
      total++; if (ram_addr !== 8'd5) begin bad++; $display("FAIL single_addr c%0d got=%0d exp=5", k, ram_addr); end
      total++; if (rsp_valid !== ev) begin bad++; $display("FAIL single_rsp_valid c%0d got=%b exp=%b", k, rsp_valid, ev); end
      if (k >= 3) begin
        total++; if (rsp_data !== mem[5]) begin bad++; $display("FAIL single_rsp_data c%0d got=%0h exp=%0h", k, rsp_data, mem[5]); end
      end
      if (k == 2) req = '0;
      $display("test_single c%0d: gnt=%b rsp_valid=%b rsp_data=%0h", k, gnt, rsp_valid, rsp_data);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] eg;
    prio = '0;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'($urandom);
    req = 3'b111;
    // requester 0 was granted last, so the pointer starts at 1
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      eg = '0; eg[k % N] = 1'b1;
      total++; if (gnt !== eg) begin bad++; $display("FAIL rr_gnt c%0d got=%b exp=%b", k, gnt, eg); end
      total++; if (rsp_valid !== e_rv) begin bad++; $display("FAIL rr_rsp_valid c%0d got=%b exp=%b", k, rsp_valid, e_rv); end
      total++; if (rsp_data !== e_rd) begin bad++; $display("FAIL rr_rsp_data c%0d got=%0h exp=%0h", k, rsp_data, e_rd); end
      $display("test_round_robin c%0d: gnt=%b rsp_valid=%b rsp_data=%0h", k, gnt, rsp_valid, rsp_data);
    end
    req = '0;
    repeat (LAT + 2) begin
      @(negedge clk);
      total++; if (rsp_valid !== e_rv || rsp_data !== e_rd) begin
        bad++; $display("FAIL rr_drain got=%b/%0h exp=%b/%0h", rsp_valid, rsp_data, e_rv, e_rd);
      end
    end
  endtask

  task automatic test_starvation();
    int found_k;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    prio = 3'b110; req = 3'b111; found_k = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (gnt === 3'b001 && found_k == 0) found_k = k;
      if (k == 1) begin
        total++; if (gnt !== 3'b010) begin bad++; $display("FAIL starve_first got=%b exp=010", gnt); end
      end
      total++; if (gnt !== m_gnt) begin bad++; $display("FAIL starve_gnt c%0d got=%b exp=%b", k, gnt, m_gnt); end
      $display("test_starvation c%0d: gnt=%b", k, gnt);
    end
    total++; if (found_k == 0 || found_k > 6) begin
      bad++; $display("FAIL starve_deadline got_cycle=%0d exp<=6", found_k);
    end
    req = '0; prio = '0;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic test_reset_inflight();
    int seen;
    req_addr[0 +: AW] = AW'($urandom) | 8'd1;
    req = 3'b001; seen = 0;
    for (int k = 0; k < 5 && seen == 0; k++) begin
      @(negedge clk);
      if (gnt[0]) seen = 1;
    end
    total++; if (seen == 0) begin bad++; $display("FAIL inflight_no_grant got=none exp=grant"); end
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (gnt !== '0) begin bad++; $display("FAIL inflight_gnt got=%b exp=000", gnt); end
    total++; if (ram_addr !== '0) begin bad++; $display("FAIL inflight_addr got=%0d exp=0", ram_addr); end
    for (int k = 0; k < LAT + 2; k++) begin
      total++; if (rsp_valid !== '0) begin bad++; $display("FAIL inflight_rsp c%0d got=%b exp=000", k, rsp_valid); end
      $display("test_reset_inflight c%0d: rsp_valid=%b", k, rsp_valid);
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] after_gnt;
    after_gnt = '0; req = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      total++; if (gnt !== m_gnt) begin bad++; $display("FAIL rand_gnt t%0d got=%b exp=%b", c, gnt, m_gnt); end
      total++; if (ram_addr !== m_addr) begin bad++; $display("FAIL rand_addr t%0d got=%0d exp=%0d", c, ram_addr, m_addr); end
      total++; if (rsp_valid !== e_rv) begin bad++; $display("FAIL rand_rsp_valid t%0d got=%b exp=%b", c, rsp_valid, e_rv); end
      total++; if (rsp_data !== e_rd) begin bad++; $display("FAIL rand_rsp_data t%0d got=%0h exp=%0h", c, rsp_data, e_rd); end
      $display("test_random t%0d: req=%b prio=%b gnt=%b addr=%0d rsp_valid=%b rsp_data=%0h",
               c, req, prio, gnt, ram_addr, rsp_valid, rsp_data);
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) begin
          after_gnt[i] = 1'b1;
        end else if (after_gnt[i]) begin
          after_gnt[i] = 1'b0;
          req[i] = 1'($urandom_range(0, 1));
          req_addr[i*AW +: AW] = AW'($urandom);
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            req_addr[i*AW +: AW] = AW'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
      prio = N'($urandom);
    end
    req = '0;
    repeat (LAT + 3) @(negedge clk);
    total++; if (rspq.size() != 0 || rsp_valid !== '0) begin
      bad++; $display("FAIL rand_drain got_pending=%0d rsp_valid=%b exp=0/000", rspq.size(), rsp_valid);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
    test_reset();
    test_single();
    test_round_robin();
    test_starvation();
    test_reset_inflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
